// File: rtl/page_input_queue.sv
// Receiving-end channel queue for the d/e/v/b stream protocol: first-word-fall-through
// storage with registered back-pressure that keeps SLACK entries free for in-flight tokens.
module page_input_queue #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int SLACK = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         in_d,
    input  logic                     in_e,
    input  logic                     in_v,
    output logic                     in_b,
    output logic [WIDTH-1:0]         out_d,
    output logic                     out_e,
    output logic                     out_v,
    input  logic                     out_b,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [CW-1:0] B_THRESH   = CW'(DEPTH - SLACK);

    logic [WIDTH:0]  mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_next;
    logic [WIDTH:0]  head;
    logic            full;
    logic            pop;
    logic            push_ok;
    logic            drop;

    assign full    = (count == FULL_COUNT);
    assign pop     = out_v && !out_b;
    // A full queue still takes a token when the head leaves on the same edge.
    assign push_ok = in_v && (!full || pop);
    assign drop    = in_v && full && !pop;

    assign count_next = count + CW'(push_ok) - CW'(pop);

    // NOTE: sequential state is updated with non-blocking assignments only, so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            in_b   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (drop)    ovf    <= 1'b1;
            count <= count_next;
            in_b  <= (count_next >= B_THRESH);
        end
    end

    // NOTE: the storage array has no reset; stale entries are never visible because
    // out_v masks the head whenever count is zero.
    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr] <= {in_e, in_d};
    end

    assign head  = mem[rd_ptr];
    assign out_v = (count != '0);
    assign out_d = out_v ? head[WIDTH-1:0] : '0;
    assign out_e = out_v ? head[WIDTH]     : 1'b0;
    assign level = count;

endmodule

// File: tb/tb_page_input_queue.sv
// Self-checking bench for page_input_queue: directed scenarios plus randomized traffic,
// every cycle compared against a queue-based behavioural model.
module tb_page_input_queue;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int SLACK = 2;

    logic                   clock;
    logic                   reset;
    logic [WIDTH-1:0]       in_d;
    logic                   in_e;
    logic                   in_v;
    logic                   in_b;
    logic [WIDTH-1:0]       out_d;
    logic                   out_e;
    logic                   out_v;
    logic                   out_b;
    logic [$clog2(DEPTH):0] level;
    logic                   ovf;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model state
    logic [WIDTH:0] mq [$];
    logic           m_ovf;
    logic           m_in_b;

    page_input_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SLACK(SLACK)) dut (
        .clock (clock),
        .reset (reset),
        .in_d  (in_d),
        .in_e  (in_e),
        .in_v  (in_v),
        .in_b  (in_b),
        .out_d (out_d),
        .out_e (out_e),
        .out_v (out_v),
        .out_b (out_b),
        .level (level),
        .ovf   (ovf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic            exp_v;
        logic [WIDTH:0]  exp_head;
        exp_v    = (mq.size() != 0);
        exp_head = exp_v ? mq[0] : '0;
        check({tag, ".out_v"}, 32'(out_v), 32'(exp_v));
        check({tag, ".out_d"}, 32'(out_d), 32'(exp_head[WIDTH-1:0]));
        check({tag, ".out_e"}, 32'(out_e), 32'(exp_head[WIDTH]));
        check({tag, ".level"}, 32'(level), 32'(mq.size()));
        check({tag, ".in_b"},  32'(in_b),  32'(m_in_b));
        check({tag, ".ovf"},   32'(ovf),   32'(m_ovf));
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf  = 1'b0;
        m_in_b = 1'b0;
    endtask

    task automatic drive(input logic v, input logic e, input logic [WIDTH-1:0] d, input logic b);
        in_v  = v;
        in_e  = e;
        in_d  = d;
        out_b = b;
    endtask

    // Advance one edge: model applies the queue rules to the pre-edge state, then compare.
    task automatic tick(input string tag);
        logic pop_m;
        pop_m = (mq.size() != 0) && !out_b;
        @(posedge clock);
        if (pop_m) void'(mq.pop_front());
        if (in_v) begin
            if (mq.size() < DEPTH) mq.push_back({in_e, in_d});
            else m_ovf = 1'b1;
        end
        m_in_b = (mq.size() >= DEPTH - SLACK);
        #1;
        check_all(tag);
    endtask

    initial begin
        reset = 1'b0;
        drive(1'b0, 1'b0, '0, 1'b1);
        model_reset();
        #1;
        check_all("reset_t0");

        // Reset held for three edges with in_v toggling
        for (int i = 0; i < 3; i++) begin
            drive(i[0] == 1'b0, 1'b1, 16'h1234 + 16'(i), 1'b0);
            @(posedge clock);
            #1;
            check_all("reset_hold");
        end
        reset = 1'b1;

        // Fill with consumer stalled, then drain
        drive(1'b1, 1'b0, 16'h0001, 1'b1); tick("fill1");
        drive(1'b1, 1'b0, 16'h0002, 1'b1); tick("fill2");
        check("fill2_in_b_const", 32'(in_b), 32'd1);
        drive(1'b1, 1'b0, 16'h0003, 1'b1); tick("fill3");
        check("fill3_level_const", 32'(level), 32'd3);
        drive(1'b0, 1'b0, '0, 1'b0);
        check("drain_head_const", 32'(out_d), 32'h0001);
        for (int i = 0; i < 4; i++) tick("drain_a");

        // Full queue with simultaneous push and pop
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 16'h000A + 16'(i), 1'b1);
            tick("full_fill");
        end
        drive(1'b1, 1'b0, 16'h000E, 1'b0); tick("full_pushpop");
        check("full_pushpop_level_const", 32'(level), 32'd4);
        check("full_pushpop_head_const", 32'(out_d), 32'h000B);
        drive(1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 5; i++) tick("drain_b");

        // Overflow: token dropped, sticky flag
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 16'h0100 + 16'(i), 1'b1);
            tick("ovf_fill");
        end
        drive(1'b1, 1'b0, 16'hDEAD, 1'b1); tick("ovf_push");
        check("ovf_const", 32'(ovf), 32'd1);
        drive(1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 5; i++) tick("ovf_drain");
        check("ovf_sticky_const", 32'(ovf), 32'd1);

        // Clear ovf, then stream 10 tokens with the last carrying EOS
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        #1;
        check_all("ovf_clear");
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 9) drive(1'b1, 1'b1, 16'h0000, 1'b0);
            else        drive(1'b1, 1'b0, 16'($urandom), 1'b0);
            tick("eos_stream");
        end
        check("eos_flag_const", 32'(out_e), 32'd1);
        drive(1'b0, 1'b0, '0, 1'b0);
        tick("eos_drain");

        // Reset pulse between edges at level 3
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 16'h0200 + 16'(i), 1'b1);
            tick("mid_fill");
        end
        drive(1'b0, 1'b0, '0, 1'b1);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_all("mid_reset");
        #1;
        reset = 1'b1;
        drive(1'b1, 1'b0, 16'h00AA, 1'b1); tick("after_reset_push");
        check("after_reset_head_const", 32'(out_d), 32'h00AA);
        drive(1'b0, 1'b0, '0, 1'b0);
        tick("after_reset_drain");

        // Randomized traffic; upstream mostly honours in_b but occasionally overruns
        for (int i = 0; i < 400; i++) begin
            logic v;
            v = ($urandom_range(0, 3) != 0) && (!in_b || ($urandom_range(0, 15) == 0));
            drive(v, ($urandom_range(0, 7) == 0), 16'($urandom), ($urandom_range(0, 2) == 0));
            tick("random");
            if ($urandom_range(0, 99) == 0) begin
                @(negedge clock);
                reset = 1'b0;
                model_reset();
                #1;
                check_all("random_reset");
                reset = 1'b1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/page_input_queue.md
Name: page_input_queue

Overview:
- Input-side channel queue for a streaming page: the receiving end of the d/e/v/b stream protocol.
- Sits between an upstream page's output channel and the page datapath/FSM (e.g. the a0..a7 inputs of a JPEG-decode transpose page).
- Absorbs tokens in flight while back-pressure propagates, and presents a first-word-fall-through token to the consumer.
- One instance per input channel; instantiated in the queued variant of the page wrapper.

Parameters:
WIDTH, 16, data bits per token (excludes the eos bit)
DEPTH, 4, storage entries; power of two, >= 4
SLACK, 2, entries kept free when in_b asserts (covers registered-b latency); 1 <= SLACK < DEPTH

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
in_d  in  WIDTH  upstream token data
in_e  in  1  upstream end-of-stream flag; qualified by in_v
in_v  in  1  upstream token valid
in_b  out  1  back-pressure to upstream (1 = stop sending)
out_d  out  WIDTH  head token data
out_e  out  1  head token end-of-stream flag
out_v  out  1  head token present
out_b  in  1  consumer back-pressure (1 = do not pop)
level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
ovf  out  1  sticky overflow flag

Behaviour:
- Interface decisions: one clock, `clock`; reset `reset` is asynchronous and active-low (reset==0 resets immediately, independent of clock).
- Storage: DEPTH x (WIDTH+1) array holding {e,d}. Pointers are wr_ptr and rd_ptr, $clog2(DEPTH) bits each, wrapping naturally modulo DEPTH. The count register is authoritative for full/empty.
- Reset values: wr_ptr=0, rd_ptr=0, count=0, in_b=0, ovf=0. This gives out_v=0, out_d=0, out_e=0, level=0. The array is not reset.
- Push request: in_v==1 at the rising edge. in_e is meaningless when in_v==0.
- Pop: out_v==1 and out_b==0 at the rising edge.
- Push acceptance: a push is accepted if count<DEPTH, or if count==DEPTH and a pop occurs in the same cycle.
- Accepted push: write {in_e,in_d} at wr_ptr, then increment wr_ptr.
- Pop: increment rd_ptr.
- Count update: count_next = count + push_accepted - pop.
- Overflow: a push that is not accepted (count==DEPTH with no pop) drops the token. ovf is then set and stays set until reset. Pointers and count are unchanged.
- Outputs are first-word-fall-through and combinational from registers:
  - out_v = (count!=0).
  - out_d/out_e = array[rd_ptr] when out_v==1; forced to 0 when out_v==0.
  - level = count.
- Latency: a token pushed at edge N is visible on out_* after edge N (one-cycle latency). There is no combinational bypass: pushing into an empty queue gives out_v=0 in that cycle.
- Back-pressure: in_b is registered. in_b <= (count_next >= DEPTH-SLACK), updated every edge.
- Upstream contract: upstream stops within SLACK cycles of seeing in_b=1. A compliant upstream never causes ovf.
- Simultaneous push and pop:
  - At count==0: the pop cannot occur (out_v=0); only the push is performed.
  - At 0<count<DEPTH and at count==DEPTH: both are performed; count unchanged; FIFO order preserved.
- EOS tokens: stored and delivered like data, with out_e=1 alongside out_v=1. The queue does not interpret EOS and keeps accepting tokens after it.
- Reset mid-operation: all queued tokens are discarded. Outputs take their reset values asynchronously; after reset is released the next accepted push is the first token out.

Test Plan:
- Reset: hold reset=0 for 3 cycles with in_v toggling -> out_v=0, out_d=0, out_e=0, in_b=0, level=0, ovf=0 throughout.
- Fill with out_b=1 (DEPTH=4, SLACK=2): push 0x0001, 0x0002, 0x0003 on consecutive edges -> level 1,2,3. in_b=1 from the edge where count reaches 2. Then out_b=0 -> out_d sequence 0x0001, 0x0002, 0x0003; in_b drops the cycle after count_next<2.
- Full plus simultaneous push/pop: fill with 0x0A..0x0D, then push 0x0E with out_b=0 on the same edge -> level stays 4, ovf=0. Drain order is 0x0B, 0x0C, 0x0D, 0x0E.
- Overflow: fill 4 with out_b=1, push 0xDEAD -> level=4, ovf=1 (sticky). Drain yields only the original 4 tokens.
- EOS and wrap: stream 10 tokens with out_b=0, the last being 0x0000 with in_e=1 -> each appears one cycle after its push, none lost. out_e=1 only on the 10th token; pointers wrap twice.
- Reset mid-operation: at level=3, pulse reset low between edges -> out_v=0, in_b=0, level=0 immediately. After release, push 0x00AA -> the first out_d is 0x00AA.
